// File: rtl/d_debounce_pkg.sv
// Shared types and default constants for the d_debounce input conditioner.
package d_debounce_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } deb_state_t;

  localparam int DEB_SYNC_STAGES   = 2;
  localparam int DEB_STABLE_CYCLES = 8;

endpackage

// File: rtl/d_debounce_bit_sync.sv
// Parameterised multi-flop synchroniser for one asynchronous bit, reset to 0.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/d_debounce.sv
// Synchronise and debounce a raw level, with optional rise/fall strobes.
// Strobe logic is compiled in only when D_DEBOUNCE_EDGE_EN is defined.
module d_debounce
  import d_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEB_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
  parameter int CNT_W         = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_raw,
  output logic                d_clean,
  output logic                rise,
  output logic                fall,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic                w_s;
  logic                w_accept_high;
  logic                w_accept_low;
  deb_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_d_clean;
  logic                r_busy;
  logic [GLITCH_W-1:0] r_glitch;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(d_raw),
    .o_q(w_s)
  );

  assign w_accept_high = (r_state == CHK_HIGH) && w_s && (r_cnt == C_LAST);
  assign w_accept_low  = (r_state == CHK_LOW) && !w_s && (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= LOW;
      r_cnt     <= '0;
      r_d_clean <= 1'b0;
      r_busy    <= 1'b0;
      r_glitch  <= '0;
    end else begin
      r_busy <= (r_state == CHK_HIGH) || (r_state == CHK_LOW);
      case (r_state)
        LOW: begin
          if (w_s) begin
            r_state <= CHK_HIGH;
            r_cnt   <= CNT_W'(1);
          end
        end
        CHK_HIGH: begin
          if (w_accept_high) begin
            r_state   <= HIGH;
            r_cnt     <= '0;
            r_d_clean <= 1'b1;
          end else if (w_s) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            // Abort: no partial credit carries into the next attempt.
            r_state <= LOW;
            r_cnt   <= '0;
            if (r_glitch != '1) r_glitch <= r_glitch + 1'b1;
          end
        end
        HIGH: begin
          if (!w_s) begin
            r_state <= CHK_LOW;
            r_cnt   <= CNT_W'(1);
          end
        end
        CHK_LOW: begin
          if (w_accept_low) begin
            r_state   <= LOW;
            r_cnt     <= '0;
            r_d_clean <= 1'b0;
          end else if (!w_s) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_state <= HIGH;
            r_cnt   <= '0;
            if (r_glitch != '1) r_glitch <= r_glitch + 1'b1;
          end
        end
        default: begin
          r_state <= LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef D_DEBOUNCE_EDGE_EN
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_accept_high;
      r_fall <= w_accept_low;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

  assign d_clean    = r_d_clean;
  assign busy       = r_busy;
  assign glitch_cnt = r_glitch;

endmodule

// File: tb/tb_d_debounce.sv
// Self-checking bench for d_debounce: run-length reference model plus directed literal checks.
module tb_d_debounce;

  localparam int SS = 2;
  localparam int SC = 8;
`ifdef D_DEBOUNCE_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       d_raw;
  logic       d_clean, rise, fall, busy;
  logic [7:0] glitch_cnt;
  logic       d_clean2, rise2, fall2, busy2;
  logic [1:0] glitch_cnt2;

  int checks = 0;
  int errors = 0;

  d_debounce u_dut (
    .clk(clk), .rst(rst), .d_raw(d_raw),
    .d_clean(d_clean), .rise(rise), .fall(fall), .busy(busy),
    .glitch_cnt(glitch_cnt)
  );

  d_debounce #(.GLITCH_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .d_raw(d_raw),
    .d_clean(d_clean2), .rise(rise2), .fall(fall2), .busy(busy2),
    .glitch_cnt(glitch_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the level seen by the filter is the raw input SS edges
  // earlier; a new level is adopted after SC consecutive differing samples,
  // and any interrupted run counts as one glitch.
  logic hist [SS];
  logic m_s;
  logic m_clean, m_rise, m_fall, m_busy;
  int   m_run, m_glitch;
  bit   started = 1'b0;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      for (int i = 0; i < SS; i++) hist[i] = 1'b0;
      m_clean = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
      m_run = 0; m_glitch = 0;
    end else begin
      m_s = hist[SS-1];
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = d_raw;
      m_busy = (m_run > 0);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_s != m_clean) begin
        m_run++;
        if (m_run == SC) begin
          m_clean = m_s;
          m_rise  = m_s;
          m_fall  = !m_s;
          m_run   = 0;
        end
      end else if (m_run > 0) begin
        m_glitch++;
        m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("d_clean", 32'(d_clean), 32'(m_clean));
      chk("rise", 32'(rise), 32'(m_rise & EDGE));
      chk("fall", 32'(fall), 32'(m_fall & EDGE));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("glitch_cnt", 32'(glitch_cnt), (m_glitch > 255) ? 32'd255 : 32'(m_glitch));
      chk("d_clean2", 32'(d_clean2), 32'(m_clean));
      chk("busy2", 32'(busy2), 32'(m_busy));
      chk("rise2", 32'(rise2), 32'(m_rise & EDGE));
      chk("fall2", 32'(fall2), 32'(m_fall & EDGE));
      chk("glitch_cnt2", 32'(glitch_cnt2), (m_glitch > 3) ? 32'd3 : 32'(m_glitch));
      chk("rise_fall_excl", 32'(rise & fall), 32'd0);
    end
  end

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    d_raw = 1'b1;
    wait_n(3);
    $display("reset held 3 cycles with d_raw=1");
    chk("lit_reset_clean", 32'(d_clean), 32'd0);
    chk("lit_reset_busy", 32'(busy), 32'd0);
    chk("lit_reset_glitch", 32'(glitch_cnt), 32'd0);
    chk("lit_reset_rise", 32'(rise), 32'd0);
    rst   = 1'b0;
    d_raw = 1'b0;
    wait_n(4);

    // Step 0->1: the next posedge is edge 0.
    d_raw = 1'b1;
    wait_n(3);
    chk("lit_step_busy_e2", 32'(busy), 32'd0);
    wait_n(1);
    chk("lit_step_busy_e3", 32'(busy), 32'd1);
    wait_n(5);
    chk("lit_step_clean_e8", 32'(d_clean), 32'd0);
    wait_n(1);
    $display("step 0->1 at edge 9: d_clean=%0d rise=%0d busy=%0d", d_clean, rise, busy);
    chk("lit_step_clean_e9", 32'(d_clean), 32'd1);
    chk("lit_step_rise_e9", 32'(rise), 32'(EDGE));
    chk("lit_step_busy_e9", 32'(busy), 32'd1);
    wait_n(1);
    chk("lit_step_busy_e10", 32'(busy), 32'd0);
    chk("lit_step_rise_e10", 32'(rise), 32'd0);
    d_raw = 1'b0;
    wait_n(12);
    chk("lit_step_back_low", 32'(d_clean), 32'd0);

    // 5-cycle pulse is rejected.
    d_raw = 1'b1;
    wait_n(5);
    d_raw = 1'b0;
    wait_n(12);
    $display("5-cycle pulse: d_clean=%0d glitch_cnt=%0d", d_clean, glitch_cnt);
    chk("lit_p5_clean", 32'(d_clean), 32'd0);
    chk("lit_p5_glitch", 32'(glitch_cnt), 32'd1);

    // 8-cycle pulse is accepted at edge 9 after its start.
    d_raw = 1'b1;
    wait_n(8);
    d_raw = 1'b0;
    wait_n(1);
    chk("lit_p8_clean_e8", 32'(d_clean), 32'd0);
    wait_n(1);
    $display("8-cycle pulse at edge 9: d_clean=%0d rise=%0d", d_clean, rise);
    chk("lit_p8_clean_e9", 32'(d_clean), 32'd1);
    chk("lit_p8_rise_e9", 32'(rise), 32'(EDGE));
    wait_n(12);
    chk("lit_p8_back_low", 32'(d_clean), 32'd0);
    chk("lit_p8_glitch", 32'(glitch_cnt), 32'd1);

    // From HIGH, toggle every cycle for 40 cycles, then hold low.
    d_raw = 1'b1;
    wait_n(12);
    chk("lit_tog_start_high", 32'(d_clean), 32'd1);
    for (int i = 0; i < 40; i++) begin
      d_raw = (i % 2 == 1);
      wait_n(1);
    end
    d_raw = 1'b0;
    wait_n(2);
    $display("after 40 toggles: d_clean=%0d glitch_cnt=%0d glitch_cnt2=%0d", d_clean, glitch_cnt, glitch_cnt2);
    chk("lit_tog_clean", 32'(d_clean), 32'd1);
    chk("lit_tog_glitch", 32'(glitch_cnt), 32'd21);
    chk("lit_tog_glitch2_sat", 32'(glitch_cnt2), 32'd3);
    wait_n(12);
    chk("lit_tog_fall_done", 32'(d_clean), 32'd0);

    // Reset sampled at edge 6 of a qualification.
    d_raw = 1'b1;
    wait_n(6);
    chk("lit_rstq_busy_e5", 32'(busy), 32'd1);
    rst = 1'b1;
    wait_n(1);
    $display("reset mid-qualification: d_clean=%0d busy=%0d glitch_cnt=%0d", d_clean, busy, glitch_cnt);
    chk("lit_rstq_clean", 32'(d_clean), 32'd0);
    chk("lit_rstq_busy", 32'(busy), 32'd0);
    chk("lit_rstq_glitch", 32'(glitch_cnt), 32'd0);
    rst   = 1'b0;
    d_raw = 1'b0;
    wait_n(12);
    chk("lit_rstq_glitch_after", 32'(glitch_cnt), 32'd0);

    // Six short glitches saturate the 2-bit counter at 3.
    for (int j = 0; j < 6; j++) begin
      d_raw = 1'b1;
      wait_n(3);
      d_raw = 1'b0;
      wait_n(5);
    end
    wait_n(4);
    $display("six glitches: glitch_cnt=%0d glitch_cnt2=%0d", glitch_cnt, glitch_cnt2);
    chk("lit_sat_glitch", 32'(glitch_cnt), 32'd6);
    chk("lit_sat_glitch2", 32'(glitch_cnt2), 32'd3);

    // Final full rise/fall cycle.
    d_raw = 1'b1;
    wait_n(14);
    chk("lit_final_high", 32'(d_clean), 32'd1);
    d_raw = 1'b0;
    wait_n(14);
    chk("lit_final_low", 32'(d_clean), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
